// File: rtl/uart_tx_if.sv
// Producer-to-transmitter word handshake; a word moves on an edge with tx_valid && tx_ready.
interface uart_tx_if #(parameter int DATA_BITS = 8);
  logic                 tx_valid;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_core.sv
// UART transmitter with transmit FIFO; frames leave back-to-back while words are queued.
// All line-side outputs are registered so tx never glitches.
module uart_tx_core #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  uart_tx_if.slave                    bus,
  output logic                        tx,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int CW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
  localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  state_t               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [CW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic                 full, empty, push, pop, baud_end;
  logic [DATA_BITS-1:0] head;

  assign full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty        = (wr_ptr_q == rd_ptr_q);
  assign push         = bus.tx_valid && !full;
  assign head         = mem_q[rd_ptr_q[AW-1:0]];
  assign baud_end     = (baud_q == BAUD_LAST);
  assign bus.tx_ready = !full;
  assign fifo_count   = wr_ptr_q - rd_ptr_q;
  assign tx           = tx_q;
  assign tx_busy      = busy_q;
  assign tx_done      = done_q;

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + BW'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pop      = 1'b0;
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        pop    = !empty;
      end
      S_START: if (baud_end) begin
        state_d = S_DATA;
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = shift_q[0];
      end
      S_DATA: if (baud_end) begin
        baud_d = '0;
        if (bit_q == DATA_LAST) begin
          bit_d = '0;
          if (PARITY_EN != 0) begin
            state_d = S_PARITY;
            tx_d    = par_q;
          end else begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end
        end else begin
          bit_d   = bit_q + CW'(1);
          shift_d = shift_q >> 1;
          tx_d    = shift_q[1];
        end
      end
      S_PARITY: if (baud_end) begin
        state_d = S_STOP;
        baud_d  = '0;
        bit_d   = '0;
        tx_d    = 1'b1;
      end
      S_STOP: begin
        // Raised one cycle early so the registered pulse lands on the final stop cycle.
        done_d = (bit_q == STOP_LAST) && (baud_q == BAUD_PRE);
        if (baud_end) begin
          baud_d = '0;
          if (bit_q != STOP_LAST) begin
            bit_d = bit_q + CW'(1);
          end else if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      state_d = S_START;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = head;
      par_d   = (^head) ^ (PARITY_ODD != 0);
      tx_d    = 1'b0;
      busy_d  = 1'b1;
    end
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.tx_data;
  end
endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: three parameterisations, table-driven frames plus
// streaming, mid-frame reset and stop-boundary push sequences.
module tb_uart_tx_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_if #(.DATA_BITS(8)) if0 ();
  uart_tx_if #(.DATA_BITS(7)) if1 ();
  uart_tx_if #(.DATA_BITS(8)) if2 ();

  logic       tx0, busy0, done0, tx1, busy1, done1, tx2, busy2, done2;
  logic [4:0] cnt0, cnt1;
  logic [2:0] cnt2;

  uart_tx_core d0 (.clk(clk), .rst_n(rst_n), .bus(if0), .tx(tx0), .tx_busy(busy0),
                   .tx_done(done0), .fifo_count(cnt0));
  uart_tx_core #(.CLKS_PER_BIT(8), .DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(1),
                 .STOP_BITS(2)) d1 (.clk(clk), .rst_n(rst_n), .bus(if1), .tx(tx1),
                 .tx_busy(busy1), .tx_done(done1), .fifo_count(cnt1));
  uart_tx_core #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) d2 (.clk(clk), .rst_n(rst_n), .bus(if2),
                 .tx(tx2), .tx_busy(busy2), .tx_done(done2), .fifo_count(cnt2));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  int         cur = 0;
  logic       tx_m, busy_m, done_m;
  logic [4:0] cnt_m;
  always_comb begin
    case (cur)
      0:       begin tx_m = tx0; busy_m = busy0; done_m = done0; cnt_m = cnt0; end
      1:       begin tx_m = tx1; busy_m = busy1; done_m = done1; cnt_m = cnt1; end
      default: begin tx_m = tx2; busy_m = busy2; done_m = done2; cnt_m = {2'b00, cnt2}; end
    endcase
  end

  task automatic to_edge(input int e);
    while (cyc < e) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push(input int s, input logic [7:0] d, output int n);
    case (s)
      0:       begin if0.tx_valid = 1'b1; if0.tx_data = d; end
      1:       begin if1.tx_valid = 1'b1; if1.tx_data = d[6:0]; end
      default: begin if2.tx_valid = 1'b1; if2.tx_data = d; end
    endcase
    @(posedge clk); #1;
    n = cyc;
    if0.tx_valid = 1'b0;
    if1.tx_valid = 1'b0;
    if2.tx_valid = 1'b0;
  endtask

  // d2 line decoder: samples mid-bit at 4 clocks per bit.
  logic       mon_en = 1'b0;
  logic [7:0] got_q[$];
  int         st_q[$];
  initial begin : mon
    int t0;
    logic [7:0] b;
    forever begin
      @(posedge clk); #2;
      if (mon_en && tx2 === 1'b0) begin
        t0 = cyc;
        b  = '0;
        for (int k = 1; k <= 9; k++) begin
          while (cyc < t0 + 4*k + 2) begin
            @(posedge clk); #2;
          end
          if (k <= 8) b[k-1] = tx2;
          else check("mon_stop_bit", {31'd0, tx2}, 32'd1);
        end
        got_q.push_back(b);
        st_q.push_back(t0);
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  typedef struct {
    int          sel;
    logic [7:0]  data;
    int          nbits;
    logic [11:0] frame;   // bit k is the k-th line bit, start bit at [0]
  } vec_t;

  vec_t       vec[8];
  logic [7:0] words[6];
  int         n, f, idx, cpb, d;
  logic       acc, saw_full, stale;

  initial begin
    vec[0] = '{0, 8'h55, 10, 12'b0010_1010_1010};
    vec[1] = '{0, 8'hA3, 10, 12'b0011_0100_0110};
    vec[2] = '{1, 8'h03, 11, 12'b0111_0000_0110};
    vec[3] = '{1, 8'h55, 11, 12'b0111_1010_1010};
    vec[4] = '{1, 8'h6E, 11, 12'b0110_1101_1100};
    vec[5] = '{2, 8'h00, 10, 12'b0010_0000_0000};
    vec[6] = '{2, 8'hFF, 10, 12'b0011_1111_1110};
    vec[7] = '{2, 8'h81, 10, 12'b0011_0000_0010};
    words  = '{8'h11, 8'hC4, 8'h7E, 8'h09, 8'hB2, 8'h5D};

    if0.tx_valid = 1'b0; if0.tx_data = '0;
    if1.tx_valid = 1'b0; if1.tx_data = '0;
    if2.tx_valid = 1'b0; if2.tx_data = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", {31'd0, tx0}, 32'd1);
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_done", {31'd0, done0}, 32'd0);
    check("rst_count", {27'd0, cnt0}, 32'd0);
    check("rst_ready", {31'd0, if0.tx_ready}, 32'd1);
    check("rst_tx_d2", {31'd0, tx2}, 32'd1);
    check("rst_ready_d2", {31'd0, if2.tx_ready}, 32'd1);
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    for (int i = 0; i < 8; i++) begin
      cur = vec[i].sel;
      cpb = (cur == 0) ? 434 : (cur == 1) ? 8 : 4;
      push(cur, vec[i].data, n);
      check($sformatf("v%0d_cnt_push", i), {27'd0, cnt_m}, 32'd1);
      check($sformatf("v%0d_tx_pre", i), {31'd0, tx_m}, 32'd1);
      to_edge(n + 1);
      check($sformatf("v%0d_busy_rise", i), {31'd0, busy_m}, 32'd1);
      check($sformatf("v%0d_cnt_pop", i), {27'd0, cnt_m}, 32'd0);
      for (int k = 0; k < vec[i].nbits; k++) begin
        to_edge(n + 1 + k*cpb + cpb/2);
        check($sformatf("v%0d_bit%0d", i, k), {31'd0, tx_m}, {31'd0, vec[i].frame[k]});
      end
      f = vec[i].nbits * cpb;
      to_edge(n + f - 1);
      check($sformatf("v%0d_done_early", i), {31'd0, done_m}, 32'd0);
      to_edge(n + f);
      check($sformatf("v%0d_done", i), {31'd0, done_m}, 32'd1);
      check($sformatf("v%0d_busy_last", i), {31'd0, busy_m}, 32'd1);
      to_edge(n + f + 1);
      check($sformatf("v%0d_done_fall", i), {31'd0, done_m}, 32'd0);
      check($sformatf("v%0d_busy_fall", i), {31'd0, busy_m}, 32'd0);
    end

    // Streaming into the 4-deep FIFO; data is garbage whenever tx_ready is low.
    cur = 2;
    got_q.delete();
    st_q.delete();
    mon_en = 1'b1;
    idx = 0;
    saw_full = 1'b0;
    if2.tx_valid = 1'b1;
    if2.tx_data  = words[0];
    for (int c = 0; c < 400 && idx < 6; c++) begin
      acc = if2.tx_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      check("stream_cnt_max", {31'd0, (cnt2 <= 3'd4)}, 32'd1);
      check("stream_ready", {31'd0, if2.tx_ready}, {31'd0, (cnt2 != 3'd4)});
      if (cnt2 == 3'd4) saw_full = 1'b1;
      if (idx < 6) if2.tx_data = if2.tx_ready ? words[idx] : 8'hEE;
      else if2.tx_valid = 1'b0;
    end
    if2.tx_valid = 1'b0;
    check("stream_all_accepted", idx, 6);
    check("stream_saw_full", {31'd0, saw_full}, 32'd1);
    for (int c = 0; c < 400 && got_q.size() < 6; c++) begin
      @(posedge clk); #1;
    end
    check("stream_frames", got_q.size(), 6);
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      check($sformatf("stream_word%0d", i), {24'd0, got_q[i]}, {24'd0, words[i]});
      if (i > 0) check($sformatf("stream_gap%0d", i), st_q[i] - st_q[i-1], 40);
    end
    to_edge(cyc + 4);
    mon_en = 1'b0;
    check("stream_idle", {31'd0, busy2}, 32'd0);

    // Reset mid-DATA with three words still queued.
    if2.tx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if2.tx_data = 8'h11 * i;
      @(posedge clk); #1;
    end
    if2.tx_valid = 1'b0;
    n = cyc;
    check("rst_pre_count", {29'd0, cnt2}, 32'd3);
    to_edge(n + 3);
    check("rst_pre_tx_low", {31'd0, tx2}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_tx", {31'd0, tx2}, 32'd1);
    check("rst_async_count", {29'd0, cnt2}, 32'd0);
    check("rst_async_busy", {31'd0, busy2}, 32'd0);
    check("rst_async_ready", {31'd0, if2.tx_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (tx2 !== 1'b1 || busy2 !== 1'b0 || cnt2 !== 3'd0) stale = 1'b1;
    end
    check("rst_no_stale_frame", {31'd0, stale}, 32'd0);

    // Push on the final STOP cycle while the FIFO is empty.
    got_q.delete();
    st_q.delete();
    mon_en = 1'b1;
    push(2, 8'h5A, n);
    to_edge(n + 40);
    check("edge_done", {31'd0, done2}, 32'd1);
    if2.tx_valid = 1'b1;
    if2.tx_data  = 8'h3C;
    @(posedge clk); #1;
    if2.tx_valid = 1'b0;
    check("edge_cnt_after_push", {29'd0, cnt2}, 32'd1);
    for (int c = 0; c < 200 && got_q.size() < 2; c++) begin
      @(posedge clk); #1;
    end
    check("edge_frames", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      check("edge_word0", {24'd0, got_q[0]}, 32'h5A);
      check("edge_word1", {24'd0, got_q[1]}, 32'h3C);
      d = st_q[1] - st_q[0];
      check("edge_gap", {31'd0, (d == 40 || d == 41)}, 32'd1);
    end
    mon_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
